top_app: RTL and testbench

Self-starting dedup streamer. After reset it reads a length byte N and N data bytes from an internal 256×8 memory. It streams the first occurrence of each byte value over a valid/ready interface, then reports how many duplicates it dropped and raises a sticky done flag. It is the application-level top block and the memory is preloaded externally.

---
 rtl/top_app_pkg.sv | 9 +
 rtl/app_mem.sv | 18 +
 rtl/top_app.sv | 85 ++++++++
 tb/tb_top_app.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/top_app_pkg.sv
// top_app_pkg: shared widths and FSM state encoding for the dedup streamer
package top_app_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  typedef enum logic [2:0] {
    RD_LEN, LAT_LEN, RD_ELEM, CHECK, OUT, NEXT, REPORT, DONE
  } state_t;
endpackage

// File: rtl/app_mem.sv
// app_mem: 256x8 array with synchronous, 1-cycle read and an optional write port
module app_mem
  import top_app_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  // write when enabled, register read data one cycle after the address
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_addr];
  end
endmodule

// File: rtl/top_app.sv
// top_app: streams the first occurrence of each byte of a length-prefixed memory list
module top_app
  import top_app_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_repeats_valid,
  output logic [7:0]        o_repeats,
  output logic              o_done
);
  state_t             r_state, w_next;
  logic [DEPTH-1:0]   r_seen;
  logic [7:0]         r_idx, r_n, r_rep;
  logic [DATA_W-1:0]  r_data, w_rdata;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_re;

  assign w_addr = (r_state == RD_ELEM) ? r_idx : '0;
  assign w_re   = (r_state == RD_LEN) || (r_state == RD_ELEM);

  app_mem mem_inst (
    .i_clk   (i_clk),
    .i_re    (w_re),
    .i_we    (1'b0),
    .i_addr  (w_addr),
    .i_wdata ('0),
    .o_rdata (w_rdata)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) r_state <= RD_LEN;
    else r_state <= w_next;

  // next-state logic; DONE is terminal until reset
  always_comb begin
    w_next = r_state;
    case (r_state)
      RD_LEN:  w_next = LAT_LEN;
      LAT_LEN: w_next = (w_rdata == '0) ? REPORT : RD_ELEM;
      RD_ELEM: w_next = CHECK;
      CHECK:   w_next = r_seen[w_rdata] ? NEXT : OUT;
      OUT:     w_next = i_ready ? NEXT : OUT;
      NEXT:    w_next = (r_idx == r_n) ? REPORT : RD_ELEM;
      REPORT:  w_next = DONE;
      default: w_next = DONE;
    endcase
  end

  // length, index, bitmap, repeat count and output data
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      r_n    <= '0;
      r_idx  <= '0;
      r_rep  <= '0;
      r_seen <= '0;
      r_data <= '0;
    end else begin
      if (r_state == LAT_LEN) begin
        r_n   <= w_rdata;
        r_idx <= 8'd1;
      end
      if (r_state == NEXT && r_idx != r_n) r_idx <= r_idx + 8'd1;
      if (r_state == CHECK) begin
        if (r_seen[w_rdata]) r_rep <= r_rep + 8'd1;
        else begin
          r_seen[w_rdata] <= 1'b1;
          r_data          <= w_rdata;
        end
      end
    end

  // outputs decoded from the current state
  always_comb begin
    o_valid         = (r_state == OUT);
    o_repeats_valid = (r_state == REPORT);
    o_done          = (r_state == DONE);
  end

  assign o_data    = r_data;
  assign o_repeats = r_rep;
endmodule

// File: tb/tb_top_app.sv
// tb_top_app: directed checks of the dedup streamer against hand-computed results
module tb_top_app;
  logic       clk = 1'b0, resetn = 1'b0, ready = 1'b0;
  logic       valid, rv, done;
  logic [7:0] data, reps;
  int         n_cmp = 0, n_bad = 0;
  int         rdy_mode = 1;
  int         rv_cnt = 0, rv_val = 0, cyc = 0, first_v = 0;
  logic [7:0] got[$], expq[$], stim[$];

  top_app dut (
    .i_clk           (clk),
    .i_resetn        (resetn),
    .i_ready         (ready),
    .o_valid         (valid),
    .o_data          (data),
    .o_repeats_valid (rv),
    .o_repeats       (reps),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    ready = (rdy_mode == 2) ? ~ready : (rdy_mode == 1);
  end

  always @(negedge clk)
    if (resetn) begin
      cyc++;
      if (valid && first_v == 0) first_v = cyc;
      if (valid && ready) got.push_back(data);
      if (rv) begin
        rv_cnt++;
        rv_val = reps;
      end
    end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    got.delete();
    rv_cnt = 0;
    rv_val = 0;
    cyc = 0;
    first_v = 0;
    #1;
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_rv", rv, 0);
    check("rst_reps", reps, 0);
    check("rst_done", done, 0);
    dut.mem_inst.mem[0] = 8'(stim.size());
    foreach (stim[i]) dut.mem_inst.mem[i+1] = stim[i];
    @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  task automatic finish_run(input string tag, input int rep_exp);
    for (int k = 0; k < 5000 && !done; k++) @(negedge clk);
    check({tag, "_done"}, done, 1);
    repeat (5) @(negedge clk);
    check({tag, "_cnt"}, got.size(), expq.size());
    foreach (expq[i]) if (i < got.size()) check({tag, "_data"}, got[i], expq[i]);
    check({tag, "_rep"}, rv_val, rep_exp);
    check({tag, "_rvpulses"}, rv_cnt, 1);
    check({tag, "_rephold"}, reps, rep_exp);
    check({tag, "_sticky"}, done, 1);
  endtask

  initial begin
    int bad;
    repeat (2) @(posedge clk);

    rdy_mode = 2;
    stim.delete();
    expq.delete();
    for (int i = 1; i <= 120; i++) begin
      stim.push_back(8'(i));
      expq.push_back(8'(i));
    end
    do_reset();
    finish_run("distinct", 0);
    check("distinct_lat", first_v, 5);

    rdy_mode = 1;
    stim = '{8'd5, 8'd5, 8'd7, 8'd5, 8'd9, 8'd7};
    expq = '{8'd5, 8'd7, 8'd9};
    do_reset();
    finish_run("dups", 3);
    check("dups_lat", first_v, 5);

    stim.delete();
    expq.delete();
    do_reset();
    repeat (3) @(negedge clk);
    check("empty_rv", rv, 1);
    check("empty_rv_done", done, 0);
    @(negedge clk);
    check("empty_rv_drop", rv, 0);
    check("empty_done", done, 1);
    finish_run("empty", 0);
    check("empty_novalid", first_v, 0);

    rdy_mode = 0;
    stim = '{8'd10, 8'd20, 8'd30};
    expq = '{8'd10, 8'd20, 8'd30};
    do_reset();
    for (int k = 0; k < 100 && !valid; k++) @(negedge clk);
    check("bp_valid", valid, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!valid || data != 8'd10) bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_nodrain", got.size(), 0);
    rdy_mode = 1;
    finish_run("bp", 0);

    stim = '{8'd0, 8'd255, 8'd0, 8'd255};
    expq = '{8'd0, 8'd255};
    do_reset();
    finish_run("zmax", 2);

    stim = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};
    expq = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};
    do_reset();
    for (int k = 0; k < 200 && got.size() < 3; k++) @(negedge clk);
    check("mid_three", got.size(), 3);
    do_reset();
    finish_run("mid", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
